modulo_n_down_counter: RTL and testbench



---
 rtl/modulo_n_down_counter.sv | 68 ++++++
 tb/tb_modulo_n_down_counter.sv | 119 +++++++++++
 2 files changed

// File: rtl/modulo_n_down_counter.sv
// Modulo-COUNT down counter with parallel load, enable, zero flag and registered tc pulse.
// Define MODULO_N_DOWN_ONESHOT_EN to halt at zero instead of wrapping.
module modulo_n_down_counter #(
  parameter int N     = 4,
  parameter int COUNT = 16
) (
  input  logic         clock,
  input  logic         clear,
  input  logic         enable,
  input  logic         load,
  input  logic [N-1:0] load_value,
  output logic [N-1:0] q,
  output logic [N-1:0] q_bar,
  output logic         zero,
  output logic         tc
);

  localparam logic [N-1:0] TOP = N'(COUNT - 1);
  localparam logic [N-1:0] ONE = N'(1);

  generate
    if (COUNT < 2 || longint'(COUNT) > (64'd1 << N)) begin : g_bad_count
      $error("modulo_n_down_counter: COUNT must satisfy 2 <= COUNT <= 2**N");
    end
  endgenerate

  logic [N-1:0] q_q, q_d;
  logic         tc_q, tc_d;

  // Load beats enable; loads above the modulus clamp to the top count.
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;
    if (load) begin
      q_d = (load_value > TOP) ? TOP : load_value;
    end else if (enable) begin
      if (q_q == '0) begin
`ifdef MODULO_N_DOWN_ONESHOT_EN
        q_d = '0;
`else
        q_d  = TOP;
        tc_d = 1'b1;
`endif
      end else begin
        q_d = q_q - ONE;
`ifdef MODULO_N_DOWN_ONESHOT_EN
        tc_d = (q_q == ONE);
`endif
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      q_q  <= TOP;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign q     = q_q;
  assign q_bar = ~q_q;
  assign zero  = (q_q == '0);
  assign tc    = tc_q;

endmodule

// File: tb/tb_modulo_n_down_counter.sv
// Directed self-checking bench: a COUNT=16 and a COUNT=10 instance share one stimulus stream.
module tb_modulo_n_down_counter;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;

  logic [3:0] q16, qb16, q10, qb10;
  logic       z16, tc16, z10, tc10;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  modulo_n_down_counter #(.N(4), .COUNT(16)) dut16 (
    .clock(clock), .clear(clear), .enable(enable), .load(load), .load_value(load_value),
    .q(q16), .q_bar(qb16), .zero(z16), .tc(tc16)
  );

  modulo_n_down_counter #(.N(4), .COUNT(10)) dut10 (
    .clock(clock), .clear(clear), .enable(enable), .load(load), .load_value(load_value),
    .q(q10), .q_bar(qb10), .zero(z10), .tc(tc10)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one edge worth of controls, then sample just after the edge.
  task automatic applyStimulus(input logic clr, input logic ld, input logic en, input logic [3:0] lv);
    clear      = clr;
    load       = ld;
    enable     = en;
    load_value = lv;
    @(posedge clock);
    #1;
  endtask

  task automatic checkBoth(input string tag, input logic [3:0] e16, input logic et16,
                           input logic [3:0] e10, input logic et10);
    logic [3:0] nb16, nb10;
    nb16 = ~e16;
    nb10 = ~e10;
    checkOutput({tag, ":q16"}, 32'(q16), 32'(e16));
    checkOutput({tag, ":tc16"}, 32'(tc16), 32'(et16));
    checkOutput({tag, ":zero16"}, 32'(z16), 32'(e16 == 4'd0));
    checkOutput({tag, ":qbar16"}, 32'(qb16), 32'(nb16));
    checkOutput({tag, ":q10"}, 32'(q10), 32'(e10));
    checkOutput({tag, ":tc10"}, 32'(tc10), 32'(et10));
    checkOutput({tag, ":zero10"}, 32'(z10), 32'(e10 == 4'd0));
    checkOutput({tag, ":qbar10"}, 32'(qb10), 32'(nb10));
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0);   checkBoth("reset", 15, 0, 9, 0);

    applyStimulus(0, 1, 1, 13); checkBoth("load13_clamp", 13, 0, 9, 0);
    applyStimulus(0, 1, 0, 3);  checkBoth("load3", 3, 0, 3, 0);
    applyStimulus(0, 1, 0, 0);  checkBoth("load0", 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 5);  checkBoth("load_beats_wrap", 5, 0, 5, 0);

    applyStimulus(0, 1, 0, 8);  checkBoth("load8", 8, 0, 8, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("dec_to7", 7, 0, 7, 0);
    applyStimulus(1, 0, 1, 0);  checkBoth("clear_mid", 15, 0, 9, 0);

    applyStimulus(0, 1, 0, 6);  checkBoth("load6", 6, 0, 6, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("en1", 5, 0, 5, 0);
    applyStimulus(0, 0, 0, 0);  checkBoth("hold_a", 5, 0, 5, 0);
    applyStimulus(0, 0, 0, 0);  checkBoth("hold_b", 5, 0, 5, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("en2", 4, 0, 4, 0);

`ifdef MODULO_N_DOWN_ONESHOT_EN
    applyStimulus(1, 0, 0, 0);  checkBoth("os_clear", 15, 0, 9, 0);
    applyStimulus(0, 1, 0, 2);  checkBoth("os_load2", 2, 0, 2, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_q1", 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_q0_first", 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_halt_a", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_halt_b", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 3);  checkBoth("os_rearm3", 3, 0, 3, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_r2", 2, 0, 2, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_r1", 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_r0_tc", 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_r0_hold", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);  checkBoth("os_load0_notc", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("os_load0_en", 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);  checkBoth("os_clear_rearm", 15, 0, 9, 0);
`else
    applyStimulus(0, 1, 0, 3);  checkBoth("w_load3", 3, 0, 3, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_2", 2, 0, 2, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_1", 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_0", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_wrap", 15, 1, 9, 1);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_after_wrap", 14, 0, 8, 0);

    applyStimulus(0, 1, 0, 0);  checkBoth("w_load0", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);  checkBoth("w_load0_wrap", 15, 1, 9, 1);
    applyStimulus(1, 0, 1, 0);  checkBoth("w_clear_cancels_tc", 15, 0, 9, 0);

    // Free-running from the top count: after k edges dut16 sits at 15-(k mod 16), dut10 at 9-(k mod 10).
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(0, 0, 1, 0);
      checkBoth($sformatf("run_k%0d", k),
                4'(15 - (k % 16)), (k % 16) == 0,
                4'(9 - (k % 10)), (k % 10) == 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
